// File: rtl/conv_seq_ctrl.sv
// Sequencer for a sliding-window convolution datapath: loads weights, streams
// IFM pixels with window tracking, drains the result pipeline, then signals done.
//   state    | meaning
//   IDLE     | waiting for a start with a usable config
//   LOAD_WGT | one-cycle weight load strobe
//   STREAM   | accepting pixels, row/col tracking
//   DRAIN    | OUT_LAT cycles for the last results to emerge
//   DONE     | one-cycle end-of-pass pulse
module conv_seq_ctrl #(
    parameter int KERNEL_SIZE = 3,
    parameter int DIM_WIDTH   = 8,
    parameter int OUT_LAT     = 2
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DIM_WIDTH-1:0]   cfg_w,
    input  logic [DIM_WIDTH-1:0]   cfg_h,
    input  logic                   ifm_valid,
    output logic                   ifm_ready,
    output logic                   set_wgt,
    output logic                   set_ifm,
    output logic                   wr_en,
    output logic                   rd_en,
    output logic                   set_reg,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic [DIM_WIDTH-1:0]   row_cnt,
    output logic [DIM_WIDTH-1:0]   col_cnt,
    output logic [2*DIM_WIDTH-1:0] out_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_WGT, S_STREAM, S_DRAIN, S_DONE} state_t;

    localparam int DRN_W = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;
    localparam logic [DIM_WIDTH-1:0] K_DIM    = DIM_WIDTH'(KERNEL_SIZE);
    localparam logic [DIM_WIDTH-1:0] K_M1     = DIM_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [DRN_W-1:0]     DRN_LOAD = DRN_W'(OUT_LAT - 1);

    state_t                 state_q, state_d;
    logic [DIM_WIDTH-1:0]   cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d;
    logic [DIM_WIDTH-1:0]   row_q, row_d, col_q, col_d;
    logic [2*DIM_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic [OUT_LAT-1:0]     dly_q, dly_d;
    logic [DRN_W-1:0]       drain_q, drain_d;
    logic                   cfg_err_q, cfg_err_d;

    logic cfg_ok, start_ok, accept, last_col, last_pix, win;

    assign cfg_ok   = (cfg_w >= K_DIM) && (cfg_h >= K_DIM);
    assign start_ok = start && cfg_ok;
    assign accept   = (state_q == S_STREAM) && ifm_valid;
    assign last_col = (col_q == cfg_w_q - 1'b1);
    assign last_pix = last_col && (row_q == cfg_h_q - 1'b1);
    assign win      = (row_q >= K_M1) && (col_q >= K_M1);

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cfg_w_q   <= '0;
            cfg_h_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            out_cnt_q <= '0;
            dly_q     <= '0;
            drain_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_w_q   <= cfg_w_d;
            cfg_h_q   <= cfg_h_d;
            row_q     <= row_d;
            col_q     <= col_d;
            out_cnt_q <= out_cnt_d;
            dly_q     <= dly_d;
            drain_q   <= drain_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start_ok) state_d = S_LOAD_WGT;
            S_LOAD_WGT: state_d = S_STREAM;
            S_STREAM:   if (accept && last_pix) state_d = S_DRAIN;
            S_DRAIN:    if (drain_q == '0) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath registers; the window delay line shifts every cycle, stalls included.
    always_comb begin
        cfg_w_d   = cfg_w_q;
        cfg_h_d   = cfg_h_q;
        row_d     = row_q;
        col_d     = col_q;
        drain_d   = drain_q;
        cfg_err_d = (state_q == S_IDLE) && start && !cfg_ok;
        out_cnt_d = out_cnt_q + {{(2*DIM_WIDTH-1){1'b0}}, dly_q[OUT_LAT-1]};
        dly_d[0]  = accept && win;
        for (int i = 1; i < OUT_LAT; i++) dly_d[i] = dly_q[i-1];

        if (state_q == S_IDLE && start_ok) begin
            cfg_w_d   = cfg_w;
            cfg_h_d   = cfg_h;
            row_d     = '0;
            col_d     = '0;
            out_cnt_d = '0;
        end
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        // Drain timer is preloaded while streaming and counts down to terminal zero.
        if (state_q == S_STREAM) drain_d = DRN_LOAD;
        else if (state_q == S_DRAIN && drain_q != '0) drain_d = drain_q - 1'b1;
    end

    always_comb begin
        ifm_ready = (state_q == S_STREAM);
        set_wgt   = (state_q == S_LOAD_WGT);
        set_ifm   = accept;
        wr_en     = accept;
        rd_en     = accept && (row_q >= K_M1);
        busy      = (state_q != S_IDLE);
        set_reg   = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        cfg_err   = cfg_err_q;
        out_valid = dly_q[OUT_LAT-1];
        row_cnt   = row_q;
        col_cnt   = col_q;
        out_cnt   = out_cnt_q;
    end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3, meaning convolution window edge length.
REQ-002 SHALL have parameter DIM_WIDTH, default 8, meaning the width of the feature-map row/column counters and config inputs.
REQ-003 SHALL have parameter OUT_LAT, default 2, meaning cycles from the accepting pixel to the datapath result.
REQ-004 SHALL have port clk1, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, meaning a request to begin one convolution pass.
REQ-007 SHALL have ports cfg_w and cfg_h, input, DIM_WIDTH each, meaning IFM columns and rows, sampled when start is accepted.
REQ-008 SHALL have ports ifm_valid (input, 1) and ifm_ready (output, 1), meaning the upstream pixel handshake.
REQ-009 SHALL have ports set_wgt, set_ifm, wr_en, rd_en and set_reg, each output, 1, meaning the datapath strobes.
REQ-010 SHALL have ports out_valid, busy, done and cfg_err, each output, 1, meaning result-valid, pass-active, end-of-pass pulse and rejected-config pulse.
REQ-011 SHALL have ports row_cnt and col_cnt, output, DIM_WIDTH each, meaning the position of the next pixel to be accepted.
REQ-012 SHALL have port out_cnt, output, 2*DIM_WIDTH, meaning the number of results produced in the current pass.

Function
REQ-013 SHALL implement an FSM with states IDLE, LOAD_WGT, STREAM, DRAIN and DONE.
REQ-014 SHALL, in IDLE with start=1 and cfg_w>=KERNEL_SIZE and cfg_h>=KERNEL_SIZE, latch the config, clear the counters and go to LOAD_WGT.
REQ-015 SHALL, in IDLE with start=1 and either dimension <KERNEL_SIZE, pulse cfg_err for 1 cycle and stay in IDLE.
REQ-016 SHALL assert set_wgt for exactly the one cycle spent in LOAD_WGT, then go to STREAM.
REQ-017 SHALL in STREAM drive ifm_ready=1; accept = ifm_valid && ifm_ready.
REQ-018 SHALL, on each accept, assert set_ifm and wr_en in that same cycle; with ifm_valid=0 no strobes are asserted and the counters hold (stall).
REQ-019 SHALL, on each accept, assert rd_en in the same cycle iff row_cnt >= KERNEL_SIZE-1.
REQ-020 SHALL, on each accept, advance col_cnt by one; at cfg_w-1 it wraps to 0 and row_cnt increments.
REQ-021 SHALL define a window as valid for an accept iff row_cnt>=KERNEL_SIZE-1 and col_cnt>=KERNEL_SIZE-1.
REQ-022 SHALL delay the window-valid flag through an OUT_LAT-stage shift register that advances every cycle, stalls included; out_valid is the register output.
REQ-023 SHALL increment out_cnt on each out_valid=1 cycle.
REQ-024 SHALL go to DRAIN on accepting pixel (cfg_h-1, cfg_w-1), with ifm_ready=0 from the next cycle.
REQ-025 SHALL stay in DRAIN exactly OUT_LAT cycles, then go to DONE.
REQ-026 SHALL pulse done for 1 cycle in DONE, then return to IDLE.
REQ-027 SHALL drive busy=1 and set_reg=1 in every state except IDLE.
REQ-028 SHALL ignore start outside IDLE, with no cfg_err and no config change.
REQ-029 SHALL give (cfg_h-K+1)*(cfg_w-K+1) results per pass, so out_cnt at done equals that value.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, enter IDLE in any state, clear all counters and the delay line, and drive every output 0 from the next cycle.
REQ-031 SHALL give rst priority over start and ifm_valid in the same cycle.

Verification
REQ-032 SHALL cover: cfg 4x4 with ifm_valid always 1 -> set_wgt 1 cycle; 16 set_ifm/wr_en; 8 rd_en; 4 out_valid, first at OUT_LAT=2 cycles after the 11th accept; done with out_cnt=4.
REQ-033 SHALL cover: cfg 2x5 with start -> cfg_err 1 cycle, busy stays 0, no strobes.
REQ-034 SHALL cover: cfg 3x3 with ifm_valid deasserted 5 cycles after the 4th pixel -> counters and strobes frozen during the stall; exactly 1 out_valid; out_cnt=1 at done.
REQ-035 SHALL cover: rst=1 mid-STREAM at pixel 6 of 4x4 -> next cycle IDLE, all outputs 0; a following 4x4 pass yields out_cnt=4.
REQ-036 SHALL cover: start pulsed during STREAM with cfg 8x8 -> ignored; the pass completes with the original 4x4 result count of 4.
REQ-037 SHALL cover: back-to-back start asserted in the DONE cycle and held -> the new pass begins from IDLE one cycle later.
